// File: rtl/ex_alu_mc.sv
// Multi-cycle integer ALU: single-cycle RV-style ops plus an iterative
// shift-add multiplier and restoring divider that share one accumulator.
module ex_alu_mc #(
   parameter int XLEN  = 32,
   parameter int M_EXT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      alu_op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            illegal
);
   localparam int SHW = $clog2(XLEN);
   localparam int CW  = $clog2(XLEN+1);

   localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_OR = 5'd3;
   localparam logic [4:0] OP_XOR = 5'd4,  OP_SLT = 5'd5,  OP_SLTU = 5'd6, OP_SLL = 5'd7;
   localparam logic [4:0] OP_SRL = 5'd8,  OP_SRA = 5'd9,  OP_LUI = 5'd10, OP_MUL = 5'd11;
   localparam logic [4:0] OP_MULH = 5'd12, OP_MULHSU = 5'd13, OP_MULHU = 5'd14;
   localparam logic [4:0] OP_DIV = 5'd15, OP_DIVU = 5'd16, OP_REM = 5'd17, OP_REMU = 5'd18;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc;       // {hi, lo}: product, or {remainder, dividend/quotient}
   logic [XLEN-1:0]   opb;       // multiplicand or divisor magnitude
   logic              neg_q, sel_hi, is_div_q;

   logic              accept, is_m, op_ill, is_mul, is_div, sgn_div, is_rem;
   logic              div_zero, div_ovf, direct, multi, a_sgn, b_sgn, last;
   logic [XLEN-1:0]   a_mag, b_mag, simple_res, direct_res, fin;
   logic [SHW-1:0]    shamt;
   logic [XLEN:0]     mul_sum, div_tmp, div_diff;
   logic [2*XLEN-1:0] acc_step, prod_fix;
   logic [XLEN-1:0]   hi_step, lo_step;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready && !flush;
   assign last      = (cnt == CW'(XLEN-1));

   // Request decode
   assign is_m     = (alu_op >= OP_MUL) && (alu_op <= OP_REMU);
   assign op_ill   = (alu_op > OP_REMU) || (is_m && (M_EXT == 0));
   assign is_mul   = is_m && !op_ill && (alu_op <= OP_MULHU);
   assign is_div   = is_m && !op_ill && (alu_op >= OP_DIV);
   assign sgn_div  = (alu_op == OP_DIV) || (alu_op == OP_REM);
   assign is_rem   = (alu_op == OP_REM) || (alu_op == OP_REMU);
   assign div_zero = (b == '0);
   assign div_ovf  = sgn_div && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
   assign direct   = is_div && (div_zero || div_ovf);
   assign multi    = (is_mul || is_div) && !direct;
   assign a_sgn    = ((alu_op == OP_MULH) || (alu_op == OP_MULHSU) || sgn_div) && a[XLEN-1];
   assign b_sgn    = ((alu_op == OP_MULH) || sgn_div) && b[XLEN-1];
   assign a_mag    = a_sgn ? -a : a;
   assign b_mag    = b_sgn ? -b : b;
   assign shamt    = b[SHW-1:0];

   always_comb begin
      simple_res = '0;
      case (alu_op)
         OP_ADD:  simple_res = a + b;
         OP_SUB:  simple_res = a - b;
         OP_AND:  simple_res = a & b;
         OP_OR:   simple_res = a | b;
         OP_XOR:  simple_res = a ^ b;
         OP_SLT:  simple_res = XLEN'($signed(a) < $signed(b));
         OP_SLTU: simple_res = XLEN'(a < b);
         OP_SLL:  simple_res = a << shamt;
         OP_SRL:  simple_res = a >> shamt;
         OP_SRA:  simple_res = XLEN'($signed(a) >>> shamt);
         OP_LUI:  simple_res = b;
         default: simple_res = '0;
      endcase
   end

   assign direct_res = div_zero ? (is_rem ? a : '1) : (is_rem ? '0 : a);

   // One iteration step; magnitudes only, sign applied once at the end
   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
   assign div_tmp  = acc[2*XLEN-1:XLEN-1];
   assign div_diff = div_tmp - {1'b0, opb};
   assign acc_step = is_div_q
      ? {(div_diff[XLEN] ? div_tmp[XLEN-1:0] : div_diff[XLEN-1:0]), acc[XLEN-2:0], !div_diff[XLEN]}
      : {mul_sum, acc[XLEN-1:1]};
   assign prod_fix = neg_q ? -acc_step : acc_step;
   assign hi_step  = acc_step[2*XLEN-1:XLEN];
   assign lo_step  = acc_step[XLEN-1:0];

   always_comb begin
      fin = '0;
      if (is_div_q) begin
         if (sel_hi) fin = neg_q ? -hi_step : hi_step;
         else        fin = neg_q ? -lo_step : lo_step;
      end else begin
         fin = sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = multi ? CALC : DONE;
         CALC:    if (last) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         acc      <= '0;
         opb      <= '0;
         neg_q    <= 1'b0;
         sel_hi   <= 1'b0;
         is_div_q <= 1'b0;
         result   <= '0;
         illegal  <= 1'b0;
      end else if (!flush) begin
         if (accept) begin
            cnt      <= '0;
            acc      <= {{XLEN{1'b0}}, a_mag};
            opb      <= b_mag;
            neg_q    <= is_rem ? a_sgn : (a_sgn ^ b_sgn);
            sel_hi   <= is_rem || (is_mul && (alu_op != OP_MUL));
            is_div_q <= is_div;
            illegal  <= op_ill;
            if (!multi) result <= op_ill ? '0 : (direct ? direct_res : simple_res);
         end else if (state == CALC) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
            if (last) result <= fin;
         end
      end
   end
endmodule
